// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754 adder/subtractor: unpack/align, add/LZC, normalise/round/pack.
// Define FP_ADD_FLAGS_EN to add the out_flags port {inexact, underflow, overflow, invalid}.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic [3:0]             out_flags
`endif
);

  localparam int unsigned W   = EXP_W + MAN_W + 1;
  localparam int unsigned MW  = MAN_W + 4;          // hidden, fraction, guard, round, sticky
  localparam int unsigned SW  = MAN_W + 5;          // MW plus carry
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned RW  = MAN_W + 2;
  localparam int unsigned SHIFT_CAP = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic out_valid_q;
  logic [W-1:0] out_sum_q;

  assign en        = !(out_valid_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  // ---------------------------------------------------------------- stage 1
  logic             sa, sb, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, a_ge;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb, fa_f, fb_f, fx, fy;
  logic             sx, sy;
  logic [MW-1:0]    my_full, y_al;
  logic [2*MW-1:0]  ext;
  logic             spec;
  logic [W-1:0]     spec_val;
  logic             spec_inv;

  assign sa     = in_a[W-1];
  assign ea     = in_a[W-2:MAN_W];
  assign fa     = in_a[MAN_W-1:0];
  assign sb     = in_b[W-1] ^ in_op;
  assign eb     = in_b[W-2:MAN_W];
  assign fb     = in_b[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_MAX) && (fa == '0);
  assign inf_b  = (eb == EXP_MAX) && (fb == '0);
  assign nan_a  = (ea == EXP_MAX) && (fa != '0);
  assign nan_b  = (eb == EXP_MAX) && (fb != '0);
  assign fa_f   = zero_a ? '0 : fa;
  assign fb_f   = zero_b ? '0 : fb;
  assign a_ge   = {ea, fa_f} >= {eb, fb_f};

  always_comb begin
    sx = a_ge ? sa : sb;
    ex = a_ge ? ea : eb;
    fx = a_ge ? fa_f : fb_f;
    sy = a_ge ? sb : sa;
    ey = a_ge ? eb : ea;
    fy = a_ge ? fb_f : fa_f;
    d  = ex - ey;
    my_full = {1'b1, fy, 3'b000};
    ext  = {my_full, {MW{1'b0}}} >> d;
    if (32'(d) >= SHIFT_CAP) begin
      y_al = {{(MW-1){1'b0}}, 1'b1};
    end else begin
      y_al = ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |ext[MW-1:0]};
    end
  end

  // Results fully decided by operand class bypass the arithmetic path.
  always_comb begin
    spec     = 1'b1;
    spec_val = '0;
    spec_inv = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      spec_val = QNAN;
      spec_inv = 1'b1;
    end else if (inf_a) begin
      spec_val = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      spec_val = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end else if (zero_a && zero_b) begin
      spec_val = {sa & sb, {(W-1){1'b0}}};
    end else if (zero_a) begin
      spec_val = {sb, eb, fb};
    end else if (zero_b) begin
      spec_val = {sa, ea, fa};
    end else begin
      spec = 1'b0;
    end
  end

  logic             s1_valid_q, s1_spec_q, s1_sx_q, s1_sub_q;
  logic [W-1:0]     s1_val_q;
  logic [EXP_W-1:0] s1_ex_q;
  logic [MW-1:0]    s1_mx_q, s1_my_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_spec_q  <= 1'b0;
      s1_sx_q    <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_val_q   <= '0;
      s1_ex_q    <= '0;
      s1_mx_q    <= '0;
      s1_my_q    <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_spec_q <= spec;
        s1_sx_q   <= sx;
        s1_sub_q  <= sx ^ sy;
        s1_val_q  <= spec_val;
        s1_ex_q   <= ex;
        s1_mx_q   <= {1'b1, fx, 3'b000};
        s1_my_q   <= y_al;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [SW-1:0]  sum_d;
  logic [LZW-1:0] lzc_d;

  assign sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                          : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});

  always_comb begin
    lzc_d = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_d[i]) lzc_d = LZW'(SW - 1 - i);
    end
  end

  logic             s2_valid_q, s2_spec_q, s2_sx_q;
  logic [W-1:0]     s2_val_q;
  logic [EXP_W-1:0] s2_ex_q;
  logic [SW-1:0]    s2_sum_q;
  logic [LZW-1:0]   s2_lzc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_spec_q  <= 1'b0;
      s2_sx_q    <= 1'b0;
      s2_val_q   <= '0;
      s2_ex_q    <= '0;
      s2_sum_q   <= '0;
      s2_lzc_q   <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_spec_q <= s1_spec_q;
        s2_sx_q   <= s1_sx_q;
        s2_val_q  <= s1_val_q;
        s2_ex_q   <= s1_ex_q;
        s2_sum_q  <= sum_d;
        s2_lzc_q  <= lzc_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [MW-1:0]    norm;
  logic [EW-1:0]    e_norm, e_fin;
  logic             g, r, s, round_up, ovf, unf, sum_zero;
  logic [MAN_W:0]   kept;
  logic [RW-1:0]    rnd;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_sum;

  always_comb begin
    if (s2_sum_q[SW-1]) begin
      norm    = MW'(s2_sum_q >> 1);
      norm[0] = s2_sum_q[1] | s2_sum_q[0];
      e_norm  = {2'b00, s2_ex_q} + EW'(1);
    end else begin
      norm   = MW'(s2_sum_q << (s2_lzc_q - LZW'(1)));
      e_norm = {2'b00, s2_ex_q} - (EW'(s2_lzc_q) - EW'(1));
    end
    kept     = norm[MW-1:3];
    g        = norm[2];
    r        = norm[1];
    s        = norm[0];
    round_up = g & (r | s | kept[0]);
    rnd      = {1'b0, kept} + RW'(round_up);
    if (rnd[RW-1]) begin
      frac  = rnd[MAN_W:1];
      e_fin = e_norm + EW'(1);
    end else begin
      frac  = rnd[MAN_W-1:0];
      e_fin = e_norm;
    end
    // e_fin is two's complement; the top bit marks a negative exponent.
    unf      = e_fin[EW-1] || (e_fin == '0);
    ovf      = !e_fin[EW-1] && (e_fin >= {2'b00, EXP_MAX});
    sum_zero = (s2_sum_q == '0);

    if (s2_spec_q)     res_sum = s2_val_q;
    else if (sum_zero) res_sum = '0;
    else if (ovf)      res_sum = {s2_sx_q, EXP_MAX, {MAN_W{1'b0}}};
    else if (unf)      res_sum = {s2_sx_q, {(W-1){1'b0}}};
    else               res_sum = {s2_sx_q, e_fin[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_sum_q <= res_sum;
    end
  end

`ifdef FP_ADD_FLAGS_EN
  logic       s1_inv_q, s2_inv_q;
  logic [3:0] res_flags, out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv_q <= 1'b0;
      s2_inv_q <= 1'b0;
    end else if (en) begin
      if (in_valid)   s1_inv_q <= spec_inv;
      if (s1_valid_q) s2_inv_q <= s1_inv_q;
    end
  end

  always_comb begin
    res_flags = 4'b0000;
    if (s2_spec_q) begin
      res_flags[0] = s2_inv_q;
    end else if (!sum_zero) begin
      res_flags[1] = ovf;
      res_flags[2] = unf && !ovf;
      res_flags[3] = g | r | s | ovf | unf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags_q <= 4'b0000;
    end else if (en && s2_valid_q) begin
      out_flags_q <= res_flags;
    end
  end

  assign out_flags = out_flags_q;
`else
  logic unused_inv;
  assign unused_inv = spec_inv;
`endif

endmodule
